// File: rtl/rotary_pkg.sv
// Shared types and Gray phase tables for the rotary quadrature generator.
// Phase index 0..2 are the moving codes; index 3 is the 00 rest code that closes a detent.
package rotary_pkg;

    typedef enum logic {DIR_CW = 1'b0, DIR_CCW = 1'b1} rot_dir_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} rot_state_t;

    localparam logic [1:0] QUAD_REST = 2'b00;
    localparam logic [1:0] CW_SEQ  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    localparam logic [1:0] CCW_SEQ [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] phase_code(input rot_dir_t dir, input logic [1:0] idx);
        return (dir == DIR_CW) ? CW_SEQ[idx] : CCW_SEQ[idx];
    endfunction

endpackage

// File: rtl/rotary_phase_timer.sv
// Free-running phase timer: o_phase_tick is high on every PHASE_CYCLES-th edge after a start.
// i_start restarts the count so the first tick lands exactly PHASE_CYCLES edges later.
module rotary_phase_timer #(
    parameter int PHASE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    output logic o_phase_tick
);

    localparam int TW = $clog2(PHASE_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(PHASE_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_start) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_phase_tick = (r_cnt == LAST);

endmodule

// File: rtl/rotary_quad_gen.sv
// Quadrature generator: turns step commands into full Gray-code detents on quad_out.
// Define ROTARY_GEN_BOUNCE_EN to overlay contact bounce on the bit that changes.
module rotary_quad_gen
    import rotary_pkg::*;
#(
    parameter int PHASE_CYCLES  = 50000,
    parameter int BOUNCE_PULSES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_steps,
    input  logic       abort,
    output logic [1:0] quad_out,
    output logic       busy,
    output logic       step_done,
    output logic [7:0] gen_pos
);

    if (PHASE_CYCLES < 4) begin : g_bad_phase
        $error("PHASE_CYCLES must be at least 4");
    end
    if (BOUNCE_PULSES < 0) begin : g_bad_bounce
        $error("BOUNCE_PULSES must be non-negative");
    end
`ifdef ROTARY_GEN_BOUNCE_EN
    if (2 * BOUNCE_PULSES >= PHASE_CYCLES) begin : g_bounce_too_long
        $error("2*BOUNCE_PULSES must be below PHASE_CYCLES");
    end
`endif

    rot_state_t r_state;
    rot_dir_t   r_dir;
    logic [1:0] r_idx;
    logic [7:0] r_steps_left;
    logic [7:0] r_pos;
    logic [1:0] r_quad;
    logic       r_step_done;
    logic       r_cmd_ready;
    logic       r_busy;

    logic       w_tick;
    logic       w_start;
    logic       w_restart;
    logic       w_advance;
    logic       w_load;
    logic [1:0] w_quad_nxt;

    rotary_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_timer (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (w_start),
        .o_phase_tick (w_tick)
    );

    // Handshake: a command transfers on an edge where cmd_valid && cmd_ready; cmd_ready is high only
    // in IDLE, so commands offered while busy are dropped. A zero-step command transfers but does nothing.
    always_comb begin
        w_start    = (r_state == ST_IDLE) && cmd_valid && (cmd_steps != 8'd0);
        w_restart  = (r_state == ST_RUN) && w_tick && (r_idx == 2'd3) &&
                     (r_steps_left != 8'd0) && !abort;
        w_advance  = (r_state == ST_RUN) && w_tick && (r_idx != 2'd3);
        w_load     = w_start || w_restart || w_advance;
        w_quad_nxt = r_quad;
        if (w_start) begin
            w_quad_nxt = phase_code(rot_dir_t'(cmd_dir), 2'd0);
        end else if (w_restart) begin
            w_quad_nxt = phase_code(r_dir, 2'd0);
        end else if (w_advance) begin
            w_quad_nxt = phase_code(r_dir, r_idx + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_CW;
            r_idx        <= 2'd0;
            r_steps_left <= 8'd0;
            r_pos        <= 8'd0;
            r_quad       <= QUAD_REST;
            r_step_done  <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            if (w_load) begin
                r_quad <= w_quad_nxt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_dir        <= rot_dir_t'(cmd_dir);
                        r_steps_left <= cmd_steps;
                        r_idx        <= 2'd0;
                        r_state      <= ST_RUN;
                        r_cmd_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_restart) begin
                        r_idx <= 2'd0;
                    end else if (w_advance) begin
                        r_idx <= r_idx + 2'd1;
                    end else if (w_tick) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                    // Abort never cuts a detent short: mid-detent it leaves exactly this one to finish.
                    if (w_advance && (r_idx == 2'd2)) begin
                        r_step_done  <= 1'b1;
                        r_pos        <= (r_dir == DIR_CW) ? r_pos + 8'd1 : r_pos - 8'd1;
                        r_steps_left <= abort ? 8'd0 : r_steps_left - 8'd1;
                    end else if (abort) begin
                        r_steps_left <= (r_idx == 2'd3) ? 8'd0 : 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ROTARY_GEN_BOUNCE_EN
    localparam int KW = $clog2(2 * BOUNCE_PULSES + 2);
    localparam logic [KW-1:0] K_END = KW'(2 * BOUNCE_PULSES);

    logic [KW-1:0] r_k;
    logic [1:0]    r_mask;
    logic [1:0]    r_quad_out;

    // r_k is the cycle count since the last transition; the old value reappears on odd counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k        <= K_END;
            r_mask     <= 2'b00;
            r_quad_out <= QUAD_REST;
        end else if (w_load) begin
            r_k        <= '0;
            r_mask     <= w_quad_nxt ^ r_quad;
            r_quad_out <= w_quad_nxt;
        end else begin
            if (r_k != K_END) begin
                r_k <= r_k + KW'(1);
            end
            if ((int'(r_k) + 1 < 2 * BOUNCE_PULSES) && !r_k[0]) begin
                r_quad_out <= r_quad ^ r_mask;
            end else begin
                r_quad_out <= r_quad;
            end
        end
    end

    assign quad_out = r_quad_out;
`else
    assign quad_out = r_quad;
`endif

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign step_done = r_step_done;
    assign gen_pos   = r_pos;

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Bench for rotary_quad_gen: directed scenarios then random commands, aborts and resets,
// every cycle compared against a timeline model of the command (edges since accept).
module tb_rotary_quad_gen;

    localparam int P   = 4;
    localparam int BP  = 1;
    localparam int DET = 4 * P;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir   = 1'b0;
    logic [7:0] cmd_steps = 8'd0;
    logic       abort     = 1'b0;
    logic       cmd_ready;
    logic [1:0] quad_out;
    logic       busy;
    logic       step_done;
    logic [7:0] gen_pos;

    always #5 clk = ~clk;

    rotary_quad_gen #(
        .PHASE_CYCLES  (P),
        .BOUNCE_PULSES (BP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .quad_out  (quad_out),
        .busy      (busy),
        .step_done (step_done),
        .gen_pos   (gen_pos)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a command is a timeline of m_t edges since accept; it lasts m_n detents of DET edges.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    int         m_n      = 0;
    bit         m_dir    = 1'b0;
    bit         m_sd     = 1'b0;
    logic [7:0] m_pos    = 8'd0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] seq_code(input bit dir, input int p);
        logic [1:0] cw  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [1:0] ccw [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        return dir ? ccw[p] : cw[p];
    endfunction

    function automatic logic [1:0] exp_quad();
        int p;
        if (!m_active) return 2'b00;
        p = (m_t % DET) / P;
`ifdef ROTARY_GEN_BOUNCE_EN
        if (((m_t % P) % 2 == 1) && ((m_t % P) < 2 * BP)) return seq_code(m_dir, (p + 3) % 4);
`endif
        return seq_code(m_dir, p);
    endfunction

    task automatic model_step(input bit v, input bit d, input logic [7:0] s, input bit ab, input bit rn);
        m_sd = 1'b0;
        if (!rn) begin
            m_active = 1'b0;
            m_t      = 0;
            m_pos    = 8'd0;
            exp_q.delete();
        end else if (!m_active) begin
            if (v && s != 8'd0) begin
                m_active = 1'b1;
                m_t      = 0;
                m_n      = int'(s);
                m_dir    = d;
            end
        end else begin
            m_t++;
            if (ab) begin
                int lim = (m_t + DET - 1) / DET;
                if (lim < m_n) m_n = lim;
            end
            if (m_t >= m_n * DET) begin
                m_active = 1'b0;
            end else if (m_t % DET == 3 * P) begin
                m_sd  = 1'b1;
                m_pos = m_dir ? m_pos - 8'd1 : m_pos + 8'd1;
                exp_q.push_back(m_pos);
            end
        end
    endtask

    task automatic compare();
        check("quad", 32'(quad_out), 32'(exp_quad()));
        check("ready", 32'(cmd_ready), 32'(!m_active));
        check("busy", 32'(busy), 32'(m_active));
        check("step_done", 32'(step_done), 32'(m_sd));
        check("gen_pos", 32'(gen_pos), 32'(m_pos));
        if (step_done) begin
            check("det_q", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) check("det_pos", 32'(gen_pos), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic cycle(input bit v, input bit d, input logic [7:0] s, input bit ab, input bit rn);
        @(negedge clk);
        cmd_valid = v;
        cmd_dir   = d;
        cmd_steps = s;
        abort     = ab;
        rst_n     = rn;
        @(posedge clk);
        #1;
        model_step(v, d, s, ab, rn);
        compare();
    endtask

    // Busy-period traffic: random offers that must be ignored, optional random aborts.
    task automatic run_until_idle(input int abort_odds);
        int guard = 0;
        while (m_active && guard < 1000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  (abort_odds > 0) && ($urandom_range(0, abort_odds) == 0), 1'b1);
            guard++;
        end
    endtask

    initial begin
        cycle(0, 0, 8'd0, 0, 0);
        cycle(0, 0, 8'd0, 0, 0);
        cycle(0, 0, 8'd0, 0, 1);

        cycle(1, 0, 8'd1, 0, 1);
        run_until_idle(0);
        cycle(1, 1, 8'd1, 0, 1);
        run_until_idle(0);
        cycle(1, 0, 8'd1, 0, 1);
        run_until_idle(0);

        cycle(1, 0, 8'd3, 0, 1);
        repeat (5) cycle(0, 0, 8'd0, 0, 1);
        cycle(0, 0, 8'd0, 1, 1);
        run_until_idle(0);

        cycle(1, 1, 8'd0, 0, 1);
        repeat (3) cycle(0, 0, 8'd0, 0, 1);

        cycle(1, 1, 8'd2, 0, 1);
        repeat (6) cycle(0, 0, 8'd0, 0, 1);
        cycle(0, 0, 8'd0, 0, 0);
        cycle(0, 0, 8'd0, 0, 1);

        for (int n = 0; n < 60; n++) begin
            cycle(1, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3)),
                  0, ($urandom_range(0, 29) != 0));
            run_until_idle(25);
            repeat ($urandom_range(0, 2)) cycle(0, 0, 8'd0, 1'($urandom_range(0, 1)), 1'b1);
        end

        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
